sfp_seq: RTL

SFP_SEQ -- requirements
Module: sfp_seq

---
 rtl/sfp_seq.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/sfp_seq.sv
// sfp_seq: sequences psum words from a source into an external accumulator,
// one group at a time (clear, accumulate num_acc words, optional ReLU,
// capture), and hands each group result to a ready/valid consumer.
// Optional stall counter enabled by defining SFP_SEQ_PERF_EN.
module sfp_seq #(
    parameter int unsigned bw      = 8,
    parameter int unsigned psum_bw = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [3:0]                num_acc,
    input  logic [7:0]                num_grp,
    input  logic                      relu_en,
    input  logic                      src_valid,
    input  logic signed [bw-1:0]      src_data,
    output logic                      src_ready,
    output logic                      sfp_clr,
    output logic                      acc,
    output logic                      relu,
    output logic signed [bw-1:0]      sfp_in,
    input  logic signed [psum_bw-1:0] sfp_out,
    output logic                      res_valid,
    output logic signed [psum_bw-1:0] res_data,
    input  logic                      res_ready,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               stall_cnt
);

    localparam int unsigned ACC_W   = 4;
    localparam int unsigned GRP_W   = 8;
    localparam int unsigned STALL_W = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_ACC  = 3'd2,
        S_RELU = 3'd3,
        S_CAP  = 3'd4,
        S_OUT  = 3'd5,
        S_FIN  = 3'd6
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [ACC_W-1:0]          r_num_acc;
    logic [GRP_W-1:0]          r_num_grp;
    logic                      r_relu_en;
    logic [ACC_W-1:0]          r_wcnt;
    logic [GRP_W-1:0]          r_gcnt;
    logic signed [psum_bw-1:0] r_res_data;

    logic w_start_acc;
    logic w_src_hs;
    logic w_last_word;
    logic w_res_hs;
    logic w_last_grp;

    // Handshake and end-of-group / end-of-job decodes
    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_src_hs    = (r_state == S_ACC) && src_valid;
    assign w_last_word = w_src_hs && (ACC_W'(r_wcnt + ACC_W'(1)) == r_num_acc);
    assign w_res_hs    = (r_state == S_OUT) && res_ready;
    assign w_last_grp  = ((GRP_W+1)'({1'b0, r_gcnt}) + (GRP_W+1)'(1)) >= (GRP_W+1)'({1'b0, r_num_grp});

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (num_grp != GRP_W'(0)) ? S_CLR : S_FIN;
                end
            end
            S_CLR:  w_next = S_ACC;
            S_ACC:  begin
                if (w_last_word) begin
                    w_next = S_RELU;
                end
            end
            S_RELU: w_next = S_CAP;
            S_CAP:  w_next = S_OUT;
            S_OUT:  begin
                if (w_res_hs) begin
                    w_next = w_last_grp ? S_FIN : S_CLR;
                end
            end
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode; src_ready/acc/sfp_in follow the source combinationally in ACC
    always_comb begin
        src_ready = 1'b0;
        sfp_clr   = 1'b0;
        acc       = 1'b0;
        relu      = 1'b0;
        sfp_in    = '0;
        res_valid = 1'b0;
        busy      = (r_state != S_IDLE);
        done      = 1'b0;
        case (r_state)
            S_CLR:  sfp_clr = 1'b1;
            S_ACC:  begin
                src_ready = 1'b1;
                acc       = src_valid;
                sfp_in    = src_data;
            end
            S_RELU: relu      = r_relu_en;
            S_OUT:  res_valid = 1'b1;
            S_FIN:  done      = 1'b1;
            default: ;
        endcase
    end

    // Job configuration latched on an accepted start; num_acc of 0 means 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_num_acc <= '0;
            r_num_grp <= '0;
            r_relu_en <= 1'b0;
        end else if (w_start_acc) begin
            r_num_acc <= (num_acc == ACC_W'(0)) ? ACC_W'(1) : num_acc;
            r_num_grp <= num_grp;
            r_relu_en <= relu_en;
        end
    end

    // Word counter: cleared per group, advances on each source handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wcnt <= '0;
        end else if (r_state == S_CLR) begin
            r_wcnt <= '0;
        end else if (w_src_hs) begin
            r_wcnt <= ACC_W'(r_wcnt + ACC_W'(1));
        end
    end

    // Group counter: cleared per job, advances on each result handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gcnt <= '0;
        end else if (w_start_acc) begin
            r_gcnt <= '0;
        end else if (w_res_hs) begin
            r_gcnt <= GRP_W'(r_gcnt + GRP_W'(1));
        end
    end

    // Capture the accumulator value once ReLU has been applied
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_res_data <= '0;
        end else if (r_state == S_CAP) begin
            r_res_data <= sfp_out;
        end
    end

    assign res_data = r_res_data;

`ifdef SFP_SEQ_PERF_EN
    logic [STALL_W-1:0] r_stall_cnt;
    logic               w_stall;

    assign w_stall = ((r_state == S_ACC) && !src_valid) ||
                     ((r_state == S_OUT) && !res_ready);

    // Saturating stall counter, cleared when a job is accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_start_acc) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {STALL_W{1'b1}})) begin
            r_stall_cnt <= STALL_W'(r_stall_cnt + STALL_W'(1));
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule
